// File: rtl/vec_pkg.sv
// Shared types for the multi-beat vector execute unit:
// lane ALU op codes, sequencer states and default geometry.
package vec_pkg;

   localparam int DEF_LANES  = 16;
   localparam int DEF_LANE_W = 16;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLL = 3'b101,
      OP_SRL = 3'b110,
      OP_MUL = 3'b111
   } valu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational vector lane: a/b operands, op, lane enable.
// Outputs res (a passed through when disabled) and zero flag.
module vec_lane_alu
   import vec_pkg::*;
#(
   parameter int LANE_W = DEF_LANE_W
) (
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   input  valu_op_e          op,
   input  logic              en,
   output logic [LANE_W-1:0] res,
   output logic              zero
);

   localparam int SH_W = $clog2(LANE_W);

   logic [LANE_W-1:0] r;
   logic [SH_W-1:0]   sh;

   assign sh = b[SH_W-1:0];

   always_comb begin
      r = '0;
      unique case (op)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SLL: r = a << sh;
         OP_SRL: r = a >> sh;
         OP_MUL: r = a * b;
         default: r = '0;
      endcase
   end

   // masked-off lanes merge the A operand and never flag zero
   assign res  = en ? r : a;
   assign zero = en & (r == '0);

endmodule

// File: rtl/vec_exec_seq.sv
// Multi-beat vector execute unit: BEAT_LANES lanes per cycle,
// lane masking, scalar broadcast, valid/ready on both sides.
// Ports: clk, reset (sync, active-high), flush; in_* operation
// side (valid/ready, op, scalar, mask, dst, va, vb, sb);
// out_* result side (valid/ready, dst, result, zero); busy.
module vec_exec_seq
   import vec_pkg::*;
#(
   parameter int LANES      = DEF_LANES,
   parameter int LANE_W     = DEF_LANE_W,
   parameter int BEAT_LANES = 4,
   parameter int REG_W      = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              in_op,
   input  logic                    in_scalar,
   input  logic [LANES-1:0]        in_mask,
   input  logic [REG_W-1:0]        in_dst,
   input  logic [LANES*LANE_W-1:0] in_va,
   input  logic [LANES*LANE_W-1:0] in_vb,
   input  logic [31:0]             in_sb,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [REG_W-1:0]        out_dst,
   output logic [LANES*LANE_W-1:0] out_result,
   output logic [LANES-1:0]        out_zero,
   output logic                    busy
);

   localparam int NBEATS = LANES / BEAT_LANES;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int VW     = LANES * LANE_W;
   localparam int BVW    = BEAT_LANES * LANE_W;
   localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

   generate
      if (LANES % BEAT_LANES != 0) begin : g_bad_beat
         $error("LANES must be a multiple of BEAT_LANES");
      end
   endgenerate

   state_e            state;
   state_e            state_nx;
   logic [BW-1:0]     beat;
   valu_op_e          op_q;
   logic [LANES-1:0]  mask_q;
   logic [REG_W-1:0]  dst_q;
   logic [VW-1:0]     va_q;
   logic [VW-1:0]     vb_q;
   logic [VW-1:0]     res_q;
   logic [LANES-1:0]  zero_q;
   logic              acc;
   logic              sb_unused;

   logic [BVW-1:0]        a_beat;
   logic [BVW-1:0]        b_beat;
   logic [BVW-1:0]        r_beat;
   logic [BEAT_LANES-1:0] m_beat;
   logic [BEAT_LANES-1:0] z_beat;

   // only the low LANE_W bits of the scalar are used
   assign sb_unused = ^in_sb;

   // DONE can hand off and accept in the same cycle
   assign in_ready = (state == IDLE)
                   | ((state == DONE) & out_ready);
   assign acc = in_valid & in_ready & ~flush;

   assign a_beat = va_q[int'(beat)*BVW +: BVW];
   assign b_beat = vb_q[int'(beat)*BVW +: BVW];
   assign m_beat = mask_q[int'(beat)*BEAT_LANES +: BEAT_LANES];

   genvar l;
   generate
      for (l = 0; l < BEAT_LANES; l++) begin : g_lane
         vec_lane_alu #(
            .LANE_W(LANE_W)
         ) u_alu (
            .a   (a_beat[l*LANE_W +: LANE_W]),
            .b   (b_beat[l*LANE_W +: LANE_W]),
            .op  (op_q),
            .en  (m_beat[l]),
            .res (r_beat[l*LANE_W +: LANE_W]),
            .zero(z_beat[l])
         );
      end
   endgenerate

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (acc) state_nx = EXEC;
         EXEC: if (beat == LAST) state_nx = DONE;
         DONE: begin
            if (out_ready)
               state_nx = in_valid ? EXEC : IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset || flush || state != EXEC)
         beat <= '0;
      else if (beat == LAST)
         beat <= '0;
      else
         beat <= beat + 1'b1;
   end

   // operands are frozen at acceptance
   always_ff @(posedge clk) begin
      if (acc) begin
         op_q   <= valu_op_e'(in_op);
         mask_q <= in_mask;
         va_q   <= in_va;
         vb_q   <= in_scalar ? {LANES{in_sb[LANE_W-1:0]}}
                             : in_vb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)    dst_q <= '0;
      else if (acc) dst_q <= in_dst;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q  <= '0;
         zero_q <= '0;
      end else if (state == EXEC) begin
         res_q[int'(beat)*BVW +: BVW] <= r_beat;
         zero_q[int'(beat)*BEAT_LANES +: BEAT_LANES] <= z_beat;
      end
   end

   assign out_valid  = (state == DONE);
   assign busy       = (state != IDLE);
   assign out_result = res_q;
   assign out_zero   = zero_q;
   assign out_dst    = dst_q;

endmodule

// File: tb/tb_vec_exec_seq.sv
// Scoreboard bench for vec_exec_seq with default geometry:
// directed ops pushed at acceptance, checked by a monitor.
module tb_vec_exec_seq;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_op;
   logic         in_scalar;
   logic [15:0]  in_mask;
   logic [4:0]   in_dst;
   logic [255:0] in_va;
   logic [255:0] in_vb;
   logic [31:0]  in_sb;
   logic         out_valid;
   logic         out_ready;
   logic [4:0]   out_dst;
   logic [255:0] out_result;
   logic [15:0]  out_zero;
   logic         busy;

   vec_exec_seq dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_scalar (in_scalar),
      .in_mask   (in_mask),
      .in_dst    (in_dst),
      .in_va     (in_va),
      .in_vb     (in_vb),
      .in_sb     (in_sb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dst   (out_dst),
      .out_result(out_result),
      .out_zero  (out_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]   dst;
      logic [255:0] res;
      logic [15:0]  zero;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   a_cyc;
   exp_t e;
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [255:0] act,
                      input logic [255:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   function automatic logic [255:0] fill(input logic [15:0] v);
      return {16{v}};
   endfunction

   function automatic exp_t mk(input logic [4:0] d,
                               input logic [255:0] r,
                               input logic [15:0] z);
      exp_t x;
      x.dst = d; x.res = r; x.zero = z;
      return x;
   endfunction

   // monitor: latency on each rising valid, data on handshake
   always @(negedge clk) begin
      if (out_valid && !prev_v) begin
         if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid cycle %0d", cyc);
         end else begin
            a_cyc = acc_q.pop_front();
            chk("latency", 256'(cyc - a_cyc), 256'(LAT));
         end
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result dst %0d", out_dst);
         end else begin
            e = exp_q.pop_front();
            chk("out_dst", 256'(out_dst), 256'(e.dst));
            chk("out_result", out_result, e.res);
            chk("out_zero", 256'(out_zero), 256'(e.zero));
         end
      end
      prev_v = out_valid;
   end

   task automatic align();
      @(posedge clk); #1;
   endtask

   // call right after a rising edge (align)
   task automatic send(input logic [2:0] op,
                       input logic sc,
                       input logic [15:0] m,
                       input logic [4:0] d,
                       input logic [255:0] a,
                       input logic [255:0] b,
                       input logic [31:0] sb,
                       input bit track,
                       input exp_t x);
      in_op = op; in_scalar = sc; in_mask = m; in_dst = d;
      in_va = a; in_vb = b; in_sb = sb; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready && !flush) begin
            @(posedge clk); #1;
            if (track) begin
               exp_q.push_back(x);
               acc_q.push_back(cyc);
            end
            in_valid = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL send_timeout op %0d", op);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) return;
      end
      checks++; errors++;
      $display("FAIL drain_timeout left %0d", exp_q.size());
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) return;
      end
      checks++; errors++;
      $display("FAIL valid_timeout");
   endtask

   logic [255:0] va2, ex2, ex_sll, vb_srl, ex_srl;

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_op = '0; in_scalar = 1'b0; in_mask = '0;
      in_dst = '0; in_va = '0; in_vb = '0; in_sb = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", 256'(out_valid), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_ready", 256'(in_ready), 256'(1));
      chk("rst_result", out_result, '0);
      chk("rst_zero", 256'(out_zero), '0);
      chk("rst_dst", 256'(out_dst), '0);

      // add, all lanes enabled
      align();
      send(3'b000, 1'b0, 16'hFFFF, 5'd7, fill(16'h0001),
           fill(16'h0002), 32'h0, 1'b1,
           mk(5'd7, fill(16'h0003), 16'h0000));
      drain();

      // scalar mul with wrap in lane 15
      for (int i = 0; i < 15; i++) begin
         va2[i*16 +: 16] = 16'(i);
         ex2[i*16 +: 16] = 16'(3 * i);
      end
      va2[255:240] = 16'hFFFF;
      ex2[255:240] = 16'hFFFD;
      align();
      send(3'b111, 1'b1, 16'hFFFF, 5'd3, va2,
           fill(16'h7777), 32'h0000_0003, 1'b1,
           mk(5'd3, ex2, 16'h0001));
      drain();

      // sub with upper half masked off
      align();
      send(3'b001, 1'b0, 16'h00FF, 5'd9, fill(16'h0005),
           fill(16'h0005), 32'h0, 1'b1,
           mk(5'd9, {{8{16'h0005}}, {8{16'h0000}}}, 16'h00FF));
      drain();

      // hold in DONE, then back-to-back hand-off
      out_ready = 1'b0;
      align();
      send(3'b100, 1'b0, 16'hFFFF, 5'd12, fill(16'h00FF),
           fill(16'h0F0F), 32'h0, 1'b1,
           mk(5'd12, fill(16'h0FF0), 16'h0000));
      wait_valid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_result", out_result, fill(16'h0FF0));
         chk("hold_ready", 256'(in_ready), 256'(0));
         chk("hold_valid", 256'(out_valid), 256'(1));
      end
      align();
      out_ready = 1'b1;
      send(3'b011, 1'b0, 16'hFFFF, 5'd13, fill(16'h1200),
           fill(16'h0034), 32'h0, 1'b1,
           mk(5'd13, fill(16'h1234), 16'h0000));
      chk("nobubble_busy", 256'(busy), 256'(1));
      drain();

      // sll with a striped mask
      for (int i = 0; i < 16; i++)
         ex_sll[i*16 +: 16] = ((i / 4) % 2 == 1) ? 16'h0010
                                                 : 16'h0001;
      align();
      send(3'b101, 1'b0, 16'hF0F0, 5'd17, fill(16'h0001),
           fill(16'h0004), 32'h0, 1'b1,
           mk(5'd17, ex_sll, 16'h0000));
      drain();

      // flush in EXEC beat 2 with a new op already offered
      align();
      send(3'b000, 1'b0, 16'hFFFF, 5'd4, fill(16'h0001),
           fill(16'h0001), 32'h0, 1'b0,
           mk(5'd0, '0, '0));
      repeat (2) align();
      flush = 1'b1;
      in_op = 3'b010; in_scalar = 1'b0; in_mask = 16'hFFFF;
      in_dst = 5'd21; in_va = fill(16'hF0F0);
      in_vb = fill(16'h3C3C); in_valid = 1'b1;
      @(negedge clk);
      chk("flush_ready", 256'(in_ready), 256'(0));
      align();
      flush = 1'b0;
      chk("flush_busy", 256'(busy), 256'(0));
      chk("flush_valid", 256'(out_valid), 256'(0));
      chk("flush_ready_nx", 256'(in_ready), 256'(1));
      send(3'b010, 1'b0, 16'hFFFF, 5'd21, fill(16'hF0F0),
           fill(16'h3C3C), 32'h0, 1'b1,
           mk(5'd21, fill(16'h3030), 16'h0000));
      drain();

      // reset while holding a result in DONE
      out_ready = 1'b0;
      align();
      send(3'b000, 1'b0, 16'hFFFF, 5'd2, fill(16'h0001),
           fill(16'h0001), 32'h0, 1'b1,
           mk(5'd2, fill(16'h0002), 16'h0000));
      wait_valid();
      align();
      reset = 1'b1;
      align();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("rst2_valid", 256'(out_valid), 256'(0));
      chk("rst2_result", out_result, '0);
      chk("rst2_zero", 256'(out_zero), '0);
      chk("rst2_dst", 256'(out_dst), '0);
      chk("rst2_busy", 256'(busy), 256'(0));
      chk("rst2_ready", 256'(in_ready), 256'(1));

      // srl: shift field 0 on even lanes, 4 on odd lanes
      for (int i = 0; i < 16; i++) begin
         vb_srl[i*16 +: 16] = (i % 2 == 1) ? 16'h0004 : 16'h0010;
         ex_srl[i*16 +: 16] = (i % 2 == 1) ? 16'h0ABC : 16'hABCD;
      end
      out_ready = 1'b1;
      align();
      send(3'b110, 1'b0, 16'hFFFF, 5'd30, fill(16'hABCD),
           vb_srl, 32'h0, 1'b1,
           mk(5'd30, ex_srl, 16'h0000));
      drain();

      repeat (2) @(negedge clk);
      chk("queue_empty", 256'(exp_q.size()), 256'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vec_exec_seq.md
Name: vec_exec_seq

Overview:
- Parametrised, multi-beat vector execute unit. It replaces the single-cycle 256-bit vector ALU in the execute stage.
- Takes a full vector operation and processes BEAT_LANES lanes per cycle, so wide vectors reuse narrow lane hardware.
- Supports lane masking and scalar-broadcast mode.
- Uses valid/ready handshakes on both sides so the pipeline hazard logic can stall on it.

Parameters:
- LANES, 16, total lanes per vector register.
- LANE_W, 16, bits per lane. Vector width is LANES*LANE_W (default 256).
- BEAT_LANES, 4, lanes processed per cycle. LANES mod BEAT_LANES must be 0, otherwise elaboration error.
- REG_W, 5, destination register index width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- flush, in, 1, abort the current operation (pipeline flush).
- in_valid, in, 1, operation offered.
- in_ready, out, 1, operation can be accepted.
- in_op, in, 3, ALU op.
- in_scalar, in, 1, 1 = use in_sb broadcast as the B operand.
- in_mask, in, LANES, per-lane enable.
- in_dst, in, REG_W, destination register tag.
- in_va, in, LANES*LANE_W, vector A.
- in_vb, in, LANES*LANE_W, vector B.
- in_sb, in, 32, scalar B (low LANE_W bits used).
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts result.
- out_dst, out, REG_W, destination tag of the result.
- out_result, out, LANES*LANE_W, result vector.
- out_zero, out, LANES, per-lane zero flag.
- busy, out, 1, state != IDLE.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (reset).
  - On reset: state=IDLE, beat counter=0, out_valid=0, out_result=0, out_zero=0, out_dst=0, busy=0, in_ready=1 in the following cycle.
- States:
  - IDLE: in_ready=1. Acceptance = in_valid & in_ready at a rising edge. On acceptance, latch op, scalar, mask, dst, va, vb (or broadcast sb) and enter EXEC with beat=0.
  - EXEC: each cycle compute lanes [beat*BEAT_LANES, +BEAT_LANES) and write them into the result/zero registers. beat increments by 1. When beat = NBEATS-1 (NBEATS = LANES/BEAT_LANES), go to DONE and reset beat to 0.
  - DONE: out_valid=1. out_result, out_zero and out_dst are held stable until out_ready.
    - out_ready & !in_valid: go to IDLE.
    - out_ready & in_valid: accept the new operation in the same cycle and go to EXEC, with no bubble.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready.
- Latency: out_valid rises NBEATS cycles after the acceptance edge. With default parameters that is 4.
- Ops (per lane; wrap modulo 2^LANE_W):
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 sll by b[log2(LANE_W)-1:0].
  - 110 srl, logical, by b[log2(LANE_W)-1:0].
  - 111 mul, low LANE_W bits of the product.
- Scalar mode: every lane's B = in_sb[LANE_W-1:0], captured at acceptance.
- Masking:
  - mask bit 0: the lane result is the A lane unchanged (merge), and its zero flag = 0.
  - mask bit 1: zero flag = (result == 0).
- Operands are captured at acceptance. Input changes after acceptance have no effect.
- Flush (synchronous, any state): go to IDLE next cycle, out_valid=0, beat=0, no result delivered.
  - flush has priority over acceptance: in_valid in the flush cycle is not accepted.
  - flush during DONE drops the held result.
- Reset mid-operation behaves like flush, and additionally zeroes the output registers.
- out_result/out_zero may change during EXEC. Consumers use them only while out_valid=1.

Decomposition:
- Package vec_pkg holds:
  - the valu_op_e enum (ADD, SUB, AND, OR, XOR, SLL, SRL, MUL; 3 bits);
  - the state_e enum (IDLE, EXEC, DONE);
  - default LANE_W/LANES localparams.
- Sub-module vec_lane_alu: combinational, one lane. Inputs a, b, op, en; outputs res, zero. Instantiated BEAT_LANES times.
- Beat lane selection is done by indexed part-select on the latched operands.

Test Plan (defaults LANES=16, LANE_W=16, BEAT_LANES=4):
1. Add, mask all 1s, va lanes=0x0001, vb lanes=0x0002: out_result all lanes 0x0003, out_zero=0x0000, out_valid rises exactly 4 cycles after acceptance, out_dst echoes in_dst=7.
2. Scalar mul, va lane i=i, lane15=0xFFFF, in_sb=0x00000003: lane i=3i for i<15, lane15=0xFFFD (wrap).
3. Sub with mask=0x00FF, va=vb=0x0005: lanes 0-7=0x0000 with zero=1; lanes 8-15=0x0005 with zero=0; out_zero=0x00FF.
4. Hold out_ready=0 for 3 cycles in DONE: outputs stable, in_ready=0. Then out_ready=1 with in_valid=1: second op accepted that edge and its result valid 4 cycles later, no bubble.
5. Assert flush during EXEC beat 2 with in_valid=1: IDLE next cycle, out_valid never rises, in_valid not accepted in the flush cycle but accepted the following cycle.
6. Assert reset while in DONE: next cycle out_valid=0, out_result=0, busy=0, in_ready=1; srl by 0x0010 (shift field 0) returns A unchanged.
